// File: rtl/fwd_pkg.sv
// Shared types, select encodings and match helpers for the forwarding/hazard unit.
package fwd_pkg;

    // Tag fields are sized for the widest supported configuration; narrower indices are zero-extended.
    localparam int unsigned TAG_RD_W  = 8;
    localparam int unsigned MAX_DEPTH = 8;
    localparam int unsigned SEL_MAX_W = 4;

    localparam int unsigned FWD_RF    = 0;
    localparam int unsigned FWD_EXMEM = 1;
    localparam int unsigned FWD_MEMWB = 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                regwrite;
        logic                memread;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    // True when this entry will write a non-zero register equal to idx.
    function automatic logic tag_writes(input tag_t t, input logic [TAG_RD_W-1:0] idx);
        return t.valid && t.regwrite && (t.rd != '0) && (t.rd == idx);
    endfunction

    // True when this entry is an in-flight load producing idx.
    function automatic logic tag_loads(input tag_t t, input logic [TAG_RD_W-1:0] idx);
        return t.memread && tag_writes(t, idx);
    endfunction

    // Smallest stage k in 1..depth whose tag t[k-1] produces rs; FWD_RF if none.
    function automatic logic [SEL_MAX_W-1:0] fwd_match(
        input tag_t [MAX_DEPTH-1:0] t,
        input int unsigned          depth,
        input logic [TAG_RD_W-1:0]  rs
    );
        logic [SEL_MAX_W-1:0] sel;
        sel = SEL_MAX_W'(FWD_RF);
        for (int k = int'(MAX_DEPTH); k >= int'(FWD_EXMEM); k--) begin
            if ((k <= int'(depth)) && tag_writes(t[k-1], rs)) begin
                sel = SEL_MAX_W'(k);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_tag_stage.sv
// One pipeline tag register: holds on freeze, loads a bubble or the upstream tag on advance.
module fwd_tag_stage
    import fwd_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic adv_i,
    input  logic bubble_i,
    input  tag_t d_i,
    output tag_t q_o
);

    tag_t tag_d;
    tag_t tag_q;

    always_comb begin : next_tag
        tag_d = tag_q;
        if (adv_i) begin
            tag_d = bubble_i ? TAG_BUBBLE : d_i;
        end
    end

    always_ff @(posedge clk_i) begin : tag_reg
        if (rst_i) begin
            tag_q <= TAG_BUBBLE;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign q_o = tag_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects for EX and load-use stall for ID, tracking in-flight destination tags.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1),
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0]  id_rs_i,
    input  logic [REG_AW-1:0]          id_rd_i,
    input  logic                       id_regwrite_i,
    input  logic                       id_memread_i,
    input  logic                       flush_i,
    input  logic                       freeze_i,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
    output logic                       stall_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    // Stage 0 is the EX entry; stage k (k >= 1) is tag entry T[k-1].
    localparam int unsigned NSTG = FWD_DEPTH + 1;

    tag_t [NSTG-1:0]         stg_in;
    tag_t [NSTG-1:0]         stg_q;
    logic [NSTG-1:0]         stg_bub;
    tag_t [MAX_DEPTH-1:0]    tvec;

    logic                       adv_c;
    logic                       stall_c;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel_c;

    logic [NUM_SRC*REG_AW-1:0]  ex_rs_d;
    logic [NUM_SRC*REG_AW-1:0]  ex_rs_q;
    logic [CNT_W-1:0]           cnt_d;
    logic [CNT_W-1:0]           cnt_q;

    assign adv_c = ~freeze_i;

    always_comb begin : stage_inputs
        stg_in  = '0;
        stg_bub = '0;
        stg_in[0].valid    = id_valid_i;
        stg_in[0].rd       = TAG_RD_W'(id_rd_i);
        stg_in[0].regwrite = id_regwrite_i;
        stg_in[0].memread  = id_memread_i;
        stg_bub[0]         = stall_c | flush_i;
        for (int i = 1; i < int'(NSTG); i++) begin
            stg_in[i] = stg_q[i-1];
        end
    end

    for (genvar g = 0; g < int'(NSTG); g++) begin : g_stage
        fwd_tag_stage u_stage (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .adv_i    (adv_c),
            .bubble_i (stg_bub[g]),
            .d_i      (stg_in[g]),
            .q_o      (stg_q[g])
        );
    end

    // Source indices ride with the EX tag; a bubble clears them.
    always_comb begin : ex_rs_next
        ex_rs_d = ex_rs_q;
        if (adv_c) begin
            ex_rs_d = stg_bub[0] ? '0 : id_rs_i;
        end
    end

    always_comb begin : fwd_select
        tvec      = '0;
        fwd_sel_c = '0;
        for (int k = 0; k < int'(FWD_DEPTH); k++) begin
            tvec[k] = stg_q[k+1];
        end
        for (int j = 0; j < int'(NUM_SRC); j++) begin
            if (stg_q[0].valid) begin
                fwd_sel_c[j*SEL_W +: SEL_W] =
                    SEL_W'(fwd_match(tvec, FWD_DEPTH, TAG_RD_W'(ex_rs_q[j*REG_AW +: REG_AW])));
            end
        end
    end

    // Loads in EX and the first LOAD_LAT-1 tag stages cannot yet supply data.
    always_comb begin : load_use
        logic hazard;
        hazard = 1'b0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            for (int j = 0; j < int'(NUM_SRC); j++) begin
                if (id_valid_i && tag_loads(stg_q[k], TAG_RD_W'(id_rs_i[j*REG_AW +: REG_AW]))) begin
                    hazard = 1'b1;
                end
            end
        end
        stall_c = hazard & ~flush_i;
    end

    always_comb begin : cnt_next
        cnt_d = cnt_q;
        if (stall_c && adv_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin : ctl_reg
        if (rst_i) begin
            ex_rs_q <= '0;
            cnt_q   <= '0;
        end else begin
            ex_rs_q <= ex_rs_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_sel_o   = fwd_sel_c;
    assign stall_o     = stall_c;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed hazard scenarios followed by random traffic.
module tb_fwd_hazard_unit;

    localparam int unsigned REG_AW    = 3;
    localparam int unsigned NUM_SRC   = 2;
    localparam int unsigned FWD_DEPTH = 3;
    localparam int unsigned LOAD_LAT  = 2;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned CNT_W     = 4;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      id_valid_i;
    logic [NUM_SRC*REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0]         id_rd_i;
    logic                      id_regwrite_i;
    logic                      id_memread_i;
    logic                      flush_i;
    logic                      freeze_i;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
    logic                      stall_o;
    logic [CNT_W-1:0]          stall_cnt_o;

    always #5 clk_i = ~clk_i;

    fwd_hazard_unit #(
        .REG_AW    (REG_AW),
        .NUM_SRC   (NUM_SRC),
        .FWD_DEPTH (FWD_DEPTH),
        .LOAD_LAT  (LOAD_LAT),
        .SEL_W     (SEL_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .freeze_i      (freeze_i),
        .fwd_sel_o     (fwd_sel_o),
        .stall_o       (stall_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    // Reference model: an array of in-flight instructions, index 0 = EX, index k = k stages after EX.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
        int rs0;
        int rs1;
    } ins_t;

    typedef struct {
        int sel0;
        int sel1;
        int stall;
        int cnt;
        int notready;
    } exp_t;

    ins_t pipe [FWD_DEPTH+1];
    int   m_cnt;
    exp_t sb_q [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic ins_t empty_ins();
        ins_t e;
        e.v = 0; e.rd = 0; e.wr = 0; e.ld = 0; e.rs0 = 0; e.rs1 = 0;
        return e;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k <= int'(FWD_DEPTH); k++) pipe[k] = empty_ins();
        m_cnt = 0;
    endfunction

    function automatic int model_sel(int rs);
        if (!pipe[0].v) return 0;
        for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
            if (pipe[k].v && pipe[k].wr && pipe[k].rd != 0 && pipe[k].rd == rs) return k;
        end
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // Apply one cycle of ID/control inputs, push the expected response, then step the model.
    task automatic drive(input bit v, input int rs0, input int rs1, input int rd, input bit wr,
                         input bit ld, input bit fl, input bit fz, input bit rs);
        exp_t e;
        ins_t n;
        bit   hz;
        @(negedge clk_i);
        #1;
        id_valid_i    = v;
        id_rs_i       = {REG_AW'(rs1), REG_AW'(rs0)};
        id_rd_i       = REG_AW'(rd);
        id_regwrite_i = wr;
        id_memread_i  = ld;
        flush_i       = fl;
        freeze_i      = fz;
        rst_i         = rs;

        hz = 0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (v && pipe[k].v && pipe[k].ld && pipe[k].wr && pipe[k].rd != 0 &&
                (pipe[k].rd == rs0 || pipe[k].rd == rs1)) hz = 1;
        end
        e.sel0  = model_sel(pipe[0].rs0);
        e.sel1  = model_sel(pipe[0].rs1);
        e.stall = (hz && !fl) ? 1 : 0;
        e.cnt   = m_cnt;
        e.notready = 0;
        for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
            if (pipe[k].v && pipe[k].ld && k < int'(LOAD_LAT)) e.notready |= (1 << k);
        end
        sb_q.push_back(e);

        if (rs) begin
            model_clear();
        end else if (!fz) begin
            if (e.stall == 1 && m_cnt < 15) m_cnt++;
            for (int k = int'(FWD_DEPTH); k >= 1; k--) pipe[k] = pipe[k-1];
            n.v = v; n.rd = rd; n.wr = wr; n.ld = ld; n.rs0 = rs0; n.rs1 = rs1;
            pipe[0] = (e.stall == 1 || fl) ? empty_ins() : n;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops one expectation per cycle once inputs have settled.
    initial begin : monitor
        exp_t e;
        int   s;
        forever begin
            @(negedge clk_i);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("fwd_sel0", int'(fwd_sel_o[SEL_W-1:0]), e.sel0);
                check("fwd_sel1", int'(fwd_sel_o[2*SEL_W-1:SEL_W]), e.sel1);
                check("stall", int'(stall_o), e.stall);
                check("stall_cnt", int'(stall_cnt_o), e.cnt);
                for (int j = 0; j < int'(NUM_SRC); j++) begin
                    s = int'(fwd_sel_o[j*SEL_W +: SEL_W]);
                    check("load_ready", (e.notready >> s) & 1, 0);
                end
            end
        end
    end

    initial begin : stimulus
        id_valid_i = 0; id_rs_i = '0; id_rd_i = '0; id_regwrite_i = 0; id_memread_i = 0;
        flush_i = 0; freeze_i = 0; rst_i = 1;
        model_clear();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;

        idle();
        // add r3 ; sub r5,r3,r4 ; reader of r3 ; drain
        drive(1, 1, 2, 3, 1, 0, 0, 0, 0);
        drive(1, 3, 4, 5, 1, 0, 0, 0, 0);
        drive(1, 6, 3, 6, 1, 0, 0, 0, 0);
        repeat (3) idle();
        // two producers of r3 then a reader
        drive(1, 1, 1, 3, 1, 0, 0, 0, 0);
        drive(1, 2, 2, 3, 1, 0, 0, 0, 0);
        drive(1, 3, 3, 7, 1, 0, 0, 0, 0);
        repeat (3) idle();
        // load-use on operand 1: stall lasts LOAD_LAT cycles, then forward from the load's stage
        drive(1, 0, 0, 2, 1, 1, 0, 0, 0);
        repeat (3) drive(1, 5, 2, 4, 1, 0, 0, 0, 0);
        repeat (4) idle();
        // r0 producers never forward or stall
        drive(1, 1, 1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 4, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 4, 1, 0, 0, 0, 0);
        repeat (3) idle();
        // load hazard squashed by flush
        drive(1, 0, 0, 4, 1, 1, 0, 0, 0);
        drive(1, 4, 4, 5, 1, 0, 1, 0, 0);
        repeat (4) idle();
        // freeze for three cycles in the middle of a stall
        drive(1, 0, 0, 6, 1, 1, 0, 0, 0);
        drive(1, 6, 1, 2, 1, 0, 0, 0, 0);
        repeat (3) drive(1, 6, 1, 2, 1, 0, 0, 1, 0);
        repeat (2) drive(1, 6, 1, 2, 1, 0, 0, 0, 0);
        repeat (4) idle();
        // reset mid-stall
        drive(1, 0, 0, 1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 3, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 3, 1, 0, 0, 1, 1);
        repeat (2) idle();
        // drive the counter into saturation
        repeat (10) begin
            drive(1, 0, 0, 7, 1, 1, 0, 0, 0);
            repeat (3) drive(1, 7, 7, 1, 1, 0, 0, 0, 0);
        end
        repeat (2) idle();

        repeat (600) begin
            drive(($urandom_range(99) < 85), int'($urandom_range(7)), int'($urandom_range(7)),
                  int'($urandom_range(7)), ($urandom_range(99) < 80), ($urandom_range(99) < 40),
                  ($urandom_range(99) < 8), ($urandom_range(99) < 12), ($urandom_range(99) < 2));
        end
        repeat (3) idle();

        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
